// File: rtl/beat_scheduler.sv
// beat_scheduler: tempo-driven beat generator and note scheduler for a rhythm game.
//
// A phase accumulator adds bpm every RUN cycle and wraps at BEAT_THRESH, emitting a
// one-cycle beat_pulse. Beats are counted up to song_beats (0 means 256), after which
// the FSM parks in DONE. Notes are produced on selected beats according to difficulty.
// Each note's lane comes from an 8-bit LFSR. Notes are held in a one-entry
// valid/ready buffer with a sticky overflow flag for dropped notes.
//
// Optional feature: define BEAT_SCHEDULER_HALFBEAT_EN so that difficulty 3 also emits
// a half-beat note once per beat period, when the accumulator first reaches
// BEAT_THRESH/2.
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   play        in   1 = run/resume, 0 = pause/return to idle
//   bpm         in   [15:0] tempo, beats per minute
//   difficulty  in   [1:0] note density select
//   song_beats  in   [7:0] song length in beats (0 = 256)
//   note_ready  in   downstream accepts the pending note
//   beat_pulse  out  one-cycle pulse per beat
//   beat_count  out  [7:0] beats since start
//   note_valid  out  a note is pending
//   note_lane   out  [1:0] lane of the pending note
//   overflow    out  sticky, a note was dropped
//   done        out  song finished
module beat_scheduler #(
  parameter longint unsigned CLK_HZ      = 50000000,
  parameter longint unsigned BEAT_THRESH = CLK_HZ * 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        play,
  input  logic [15:0] bpm,
  input  logic [1:0]  difficulty,
  input  logic [7:0]  song_beats,
  input  logic        note_ready,
  output logic        beat_pulse,
  output logic [7:0]  beat_count,
  output logic        note_valid,
  output logic [1:0]  note_lane,
  output logic        overflow,
  output logic        done
);

  localparam logic [32:0] Thresh   = 33'(BEAT_THRESH);
  localparam logic [7:0]  LfsrSeed = 8'hA5;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
  localparam logic [32:0] HalfThresh = Thresh >> 1;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        pulse_q, pulse_d;
  logic        nv_q, nv_d;
  logic [1:0]  lane_q, lane_d;
  logic        ovf_q, ovf_d;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
  logic        half_q, half_d;
`endif

  logic [32:0] sum;
  logic        wrap;
  logic        finishing;
  logic        beat_note;
  logic        new_note;
  logic        clr_ovf;
  logic [7:0]  lfsr_adv;

  // Accumulator stays below Thresh, so the 33-bit sum cannot overflow for sane thresholds.
  assign sum       = acc_q + 33'(bpm);
  assign wrap      = (sum >= Thresh);
  // The beat that reaches song_beats is visible as pulse_q; leave RUN on the next edge.
  assign finishing = pulse_q && (cnt_q == song_beats);
  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left.
  assign lfsr_adv  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    case (difficulty)
      2'd0:    beat_note = (cnt_q[1:0] == 2'b00);
      2'd1:    beat_note = ~cnt_q[0];
      default: beat_note = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    pulse_d  = 1'b0;
    new_note = 1'b0;
    clr_ovf  = 1'b0;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
    half_d   = half_q;
`endif
    case (state_q)
      StIdle: begin
        if (play) begin
          state_d = StRun;
          acc_d   = '0;
          cnt_d   = '0;
          lfsr_d  = LfsrSeed;
          clr_ovf = 1'b1;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
          half_d  = 1'b0;
`endif
        end
      end
      StRun: begin
        if (finishing) begin
          state_d = StDone;
        end else if (!play) begin
          state_d = StPause;
        end else if (wrap) begin
          acc_d    = sum - Thresh;
          pulse_d  = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          lfsr_d   = lfsr_adv;
          new_note = beat_note;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
          half_d   = 1'b0;
`endif
        end else begin
          acc_d = sum;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
          if ((difficulty == 2'd3) && !half_q && (sum >= HalfThresh)) begin
            half_d   = 1'b1;
            lfsr_d   = lfsr_adv;
            new_note = 1'b1;
          end
`endif
        end
      end
      StPause: begin
        if (play) state_d = StRun;
      end
      StDone: begin
        if (!play) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One-entry note buffer: a new note is dropped only when the slot is full and stalled.
  always_comb begin
    nv_d   = nv_q;
    lane_d = lane_q;
    ovf_d  = clr_ovf ? 1'b0 : ovf_q;
    if (new_note) begin
      if (nv_q && !note_ready) begin
        ovf_d = 1'b1;
      end else begin
        nv_d   = 1'b1;
        lane_d = lfsr_d[1:0];
      end
    end else if (nv_q && note_ready) begin
      nv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LfsrSeed;
      pulse_q <= 1'b0;
      nv_q    <= 1'b0;
      lane_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
      half_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      pulse_q <= pulse_d;
      nv_q    <= nv_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
`ifdef BEAT_SCHEDULER_HALFBEAT_EN
      half_q  <= half_d;
`endif
    end
  end

  assign beat_pulse = pulse_q;
  assign beat_count = cnt_q;
  assign note_valid = nv_q;
  assign note_lane  = lane_q;
  assign overflow   = ovf_q;
  assign done       = (state_q == StDone);

endmodule

// File: doc/beat_scheduler.md
BEAT_SCHEDULER -- requirements
Module: beat_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BEAT_THRESH, default CLK_HZ*60, phase-accumulator wrap threshold.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 play  input  1  level; 1 = run or resume the song, 0 = pause or return to idle.
REQ-006 bpm  input  16  tempo in beats per minute; 0 = no beats.
REQ-007 difficulty  input  2  note density select.
REQ-008 song_beats  input  8  song length in beats; 0 is treated as 256.
REQ-009 note_ready  input  1  downstream accepts the note.
REQ-010 beat_pulse  output  1  one-cycle pulse on each beat.
REQ-011 beat_count  output  8  beats elapsed since start.
REQ-012 note_valid  output  1  a note is pending.
REQ-013 note_lane  output  2  arrow lane of the pending note.
REQ-014 overflow  output  1  sticky; a note was dropped.
REQ-015 done  output  1  song finished.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
- IDLE to RUN: on play=1; the accumulator and beat_count clear; overflow clears.
- RUN to PAUSE: on play=0.
- PAUSE to RUN: on play=1; the accumulator and beat_count are held.
- RUN to DONE: on the cycle after the final beat.
- DONE to IDLE: on play=0.
REQ-017 In RUN, the 33-bit accumulator SHALL add bpm each cycle. When the sum is >= BEAT_THRESH, the next value SHALL be sum-BEAT_THRESH and beat_pulse SHALL be 1 in the following cycle.
REQ-018 beat_count SHALL increment with each beat_pulse. When it reaches song_beats (8-bit wrap, so 0 means 256), the FSM SHALL enter DONE.
REQ-019 done SHALL be 1 only in DONE. beat_pulse SHALL never assert outside RUN.
REQ-020 An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5, reseeded on IDLE to RUN) SHALL advance once per beat_pulse.
REQ-021 A note SHALL be generated on a beat when:
- difficulty 0: beat_count[1:0]==0;
- difficulty 1: beat_count[0]==0;
- difficulty 2 or 3: every beat.
The lane is LFSR[1:0] after the advance. beat_count here is the pre-increment value.
REQ-022 The note buffer SHALL hold one entry. note_valid and note_ready are a valid/ready pair, and a note transfers when both are 1.
REQ-023 If a new note arrives while note_valid=1 and note_ready=0, the new note SHALL be dropped, the pending note kept, and overflow set to 1.
REQ-024 On a simultaneous transfer and new note, the new note SHALL load and note_valid SHALL stay 1.
REQ-025 Pending notes SHALL survive PAUSE and DONE. A note SHALL NOT clear until it is accepted or reset.
REQ-026 A bpm change SHALL take effect on the next cycle, with no accumulator reset.

Reset
REQ-027 With resetn=0 at a clock edge, the following SHALL hold from the next cycle:
- state = IDLE;
- accumulator = 0, beat_count = 0, LFSR = 8'hA5;
- beat_pulse, note_valid, note_lane, overflow and done = 0.
REQ-028 Reset SHALL take priority over all inputs, including mid-RUN and mid-handshake.

Configuration
REQ-029 Macro BEAT_SCHEDULER_HALFBEAT_EN:
- When defined, difficulty 3 SHALL also generate a note on the first cycle where the accumulator is >= BEAT_THRESH/2 within each beat period (half-beat). That note uses the same LFSR advance rule and buffer rules, with no beat_pulse and no beat_count change.
- When undefined, difficulty 3 behaves identically to difficulty 2.

Verification
REQ-030 CLK_HZ=100 (BEAT_THRESH=6000), bpm=120, play=1 -> first beat_pulse 51 cycles after play, then one every 50 cycles.
REQ-031 song_beats=4, difficulty=0, note_ready=1 -> notes on beats 1 and 5 only is invalid. The required response is one note (beat_count 0), then done=1 after the 4th beat. After play=0, the FSM is in IDLE with done=0.
REQ-032 difficulty=2, note_ready=0 for 3 beats -> note_valid=1 holding the first lane, and overflow=1 after the second beat.
REQ-033 play toggled to 0 for 200 cycles mid-beat -> no beat_pulse during the pause, and beat phase resumes exactly where it stopped.
REQ-034 resetn=0 during RUN with note_valid=1 -> all outputs 0 next cycle. play held at 1 -> RUN restarts with beat_count=0.
REQ-035 Macro defined, difficulty=3, bpm=120, note_ready=1 -> two notes per 50-cycle beat period, with a half-beat note 25 cycles after each beat.
